// File: rtl/filter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// filter_pkg: shared widths, issuer FSM states and coefficient record.
// Rev 1.0
// ----------------------------------------------------------------------------
package filter_pkg;

  localparam int DATA_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a1;
    logic [DATA_W-1:0] b1;
    logic [DATA_W-1:0] b0;
  } coef_t;

endpackage
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_sync: single-clock FIFO with occupancy output, reset and clear.
// Rev 1.0
// ----------------------------------------------------------------------------
module fifo_sync #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   level_q;
  logic              do_wr;
  logic              do_rd;

  // A full FIFO refuses the write even when a read frees a slot on the same edge.
  assign do_wr     = wr_en_i && (level_q != (ADDR_W+1)'(DEPTH));
  assign do_rd     = rd_en_i && (level_q != '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk) begin
    if (!rst_i && !clr_i && do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/filter_input_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// filter_input_buffer: buffers samples, issues paced din/vin strobes, and
// double-buffers the a1/b1/b0 coefficients so they only change while vin=0.
// Rev 1.0
// ----------------------------------------------------------------------------
module filter_input_buffer
  import filter_pkg::*;
#(
  parameter int DATA_W = filter_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int GAP    = 0
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              flush,
  input  logic [DATA_W-1:0] coef_a1,
  input  logic [DATA_W-1:0] coef_b1,
  input  logic [DATA_W-1:0] coef_b0,
  input  logic              coef_load,
  output logic              coef_pend,
  output logic [ADDR_W:0]   level,
  output logic [DATA_W-1:0] din,
  output logic              vin,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] b0
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              vin_q, vin_d;
  logic [DATA_W-1:0] din_q, din_d;
  coef_t             shadow_q, shadow_d;
  coef_t             coef_q, coef_d;
  logic              pend_q, pend_d;

  logic [DATA_W-1:0] head;
  logic              wr_en;
  logic              pop;
  logic              commit;
  logic              issue_slot;

  assign s_ready = !rstN && (level != (ADDR_W+1)'(DEPTH));
  assign wr_en   = s_valid && s_ready && !flush;

  fifo_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_i     (rstN),
    .clr_i     (flush),
    .wr_en_i   (wr_en),
    .wr_data_i (s_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .level_o   (level)
  );

  // A pending shadow always commits on the next edge; it steals the issue slot
  // if there is one, so the cycle after a commit never carries vin=1.
  assign commit = pend_q;

  always_comb begin
    issue_slot = 1'b0;
    case (state_q)
      ST_IDLE:  issue_slot = 1'b1;
      ST_ISSUE: issue_slot = (GAP == 0);
      ST_GAP:   issue_slot = (gap_cnt_q == GAP_W'(1));
      default:  issue_slot = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    vin_d     = 1'b0;
    din_d     = din_q;
    pop       = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      gap_cnt_d = '0;
    end else if (issue_slot && (level != '0) && !commit) begin
      state_d   = ST_ISSUE;
      gap_cnt_d = '0;
      vin_d     = 1'b1;
      din_d     = head;
      pop       = 1'b1;
    end else if ((state_q == ST_ISSUE) && (GAP > 0)) begin
      state_d   = ST_GAP;
      gap_cnt_d = GAP_W'(GAP);
    end else if ((state_q == ST_GAP) && (gap_cnt_q > GAP_W'(1))) begin
      state_d   = ST_GAP;
      gap_cnt_d = gap_cnt_q - 1'b1;
    end else begin
      state_d   = ST_IDLE;
      gap_cnt_d = '0;
    end
  end

  // A load on a commit edge lands in the shadow after the old shadow moves out.
  always_comb begin
    shadow_d = shadow_q;
    coef_d   = coef_q;
    pend_d   = pend_q;
    if (commit) begin
      coef_d = shadow_q;
      pend_d = 1'b0;
    end
    if (coef_load) begin
      shadow_d = '{a1: coef_a1, b1: coef_b1, b0: coef_b0};
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      vin_q     <= 1'b0;
      din_q     <= '0;
      shadow_q  <= '0;
      coef_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      vin_q     <= vin_d;
      din_q     <= din_d;
      shadow_q  <= shadow_d;
      coef_q    <= coef_d;
      pend_q    <= pend_d;
    end
  end

  assign vin       = vin_q;
  assign din       = din_q;
  assign coef_pend = pend_q;
  assign a1        = coef_q.a1;
  assign b1        = coef_q.b1;
  assign b0        = coef_q.b0;

endmodule
`default_nettype wire

// File: tb/tb_filter_input_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_filter_input_buffer: scoreboard bench driving a GAP=0 and a GAP=2 buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_filter_input_buffer;

  localparam int DW    = 11;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN, s_valid, flush, coef_load;
  logic [DW-1:0] s_data, coef_a1, coef_b1, coef_b0;

  logic          s_ready0, coef_pend0, vin0;
  logic [AW:0]   level0;
  logic [DW-1:0] din0, a1_0, b1_0, b0_0;
  logic          s_ready2, coef_pend2, vin2;
  logic [AW:0]   level2;
  logic [DW-1:0] din2, a1_2, b1_2, b0_2;

  filter_input_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .GAP(0)) dut0 (
    .clk(clk), .rstN(rstN), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
    .flush(flush), .coef_a1(coef_a1), .coef_b1(coef_b1), .coef_b0(coef_b0),
    .coef_load(coef_load), .coef_pend(coef_pend0), .level(level0), .din(din0),
    .vin(vin0), .a1(a1_0), .b1(b1_0), .b0(b0_0)
  );

  filter_input_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .GAP(2)) dut2 (
    .clk(clk), .rstN(rstN), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
    .flush(flush), .coef_a1(coef_a1), .coef_b1(coef_b1), .coef_b0(coef_b0),
    .coef_load(coef_load), .coef_pend(coef_pend2), .level(level2), .din(din2),
    .vin(vin2), .a1(a1_2), .b1(b1_2), .b0(b0_2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues and coefficient reference, advanced on every rising edge.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q2[$];
  int            acc0 = 0;
  int            epoch = 0;
  int            cyc = 0;
  logic [DW-1:0] m_a1 = '0, m_b1 = '0, m_b0 = '0;
  logic [DW-1:0] sh_a1 = '0, sh_b1 = '0, sh_b0 = '0;
  logic          m_pend = 1'b0;
  logic          m_commit = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rstN || flush) begin
      q0.delete();
      q2.delete();
      epoch <= epoch + 1;
    end else begin
      if (s_valid && s_ready0) begin
        q0.push_back(s_data);
        acc0 <= acc0 + 1;
      end
      if (s_valid && s_ready2) q2.push_back(s_data);
    end
    if (rstN) begin
      m_a1 <= '0; m_b1 <= '0; m_b0 <= '0;
      sh_a1 <= '0; sh_b1 <= '0; sh_b0 <= '0;
      m_pend <= 1'b0;
      m_commit <= 1'b0;
    end else begin
      m_commit <= m_pend;
      if (m_pend) begin
        m_a1 <= sh_a1; m_b1 <= sh_b1; m_b0 <= sh_b0;
      end
      if (coef_load) begin
        sh_a1 <= coef_a1; sh_b1 <= coef_b1; sh_b0 <= coef_b0;
        m_pend <= 1'b1;
      end else begin
        m_pend <= 1'b0;
      end
    end
  end

  int   last2 = 0;
  int   last_epoch = -1;
  int   vcount0 = 0;
  int   t2[$];
  logic rec2 = 1'b0;

  always @(negedge clk) begin
    chk_eq("a1_0", a1_0, m_a1);
    chk_eq("b1_0", b1_0, m_b1);
    chk_eq("b0_0", b0_0, m_b0);
    chk_eq("pend_0", coef_pend0, m_pend);
    chk_eq("a1_2", a1_2, m_a1);
    chk_eq("b1_2", b1_2, m_b1);
    chk_eq("b0_2", b0_2, m_b0);
    chk_eq("pend_2", coef_pend2, m_pend);
    if (m_commit) begin
      chk_eq("commit_vin0", vin0, 0);
      chk_eq("commit_vin2", vin2, 0);
    end
    if (vin0) begin
      vcount0 <= vcount0 + 1;
      chk_eq("sb0_avail", q0.size() != 0, 1);
      if (q0.size() != 0) chk_eq("din0", din0, q0.pop_front());
    end
    if (vin2) begin
      chk_eq("sb2_avail", q2.size() != 0, 1);
      if (q2.size() != 0) chk_eq("din2", din2, q2.pop_front());
      if (last_epoch == epoch) chk_eq("gap2_min", (cyc - last2) >= 3, 1);
      last_epoch <= epoch;
      last2 <= cyc;
      if (rec2) t2.push_back(cyc);
    end
  end

  logic          vh [24];
  logic          ph [24];
  logic [DW-1:0] a1h[24], b1h[24], b0h[24];
  int            n, run, first, last, ones, gaps, base, vref;

  initial begin
    rstN = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0;
    coef_load = 1'b0; coef_a1 = '0; coef_b1 = '0; coef_b0 = '0;

    // Reset
    repeat (2) @(negedge clk);
    chk_eq("rst_vin", vin0, 0);
    chk_eq("rst_level", level0, 0);
    chk_eq("rst_ready", s_ready0, 0);
    chk_eq("rst_a1", a1_0, 0);
    rstN = 1'b0;
    @(negedge clk);
    chk_eq("rel_ready", s_ready0, 1);
    chk_eq("rel_level", level0, 0);
    chk_eq("rel_din", din0, 0);

    // Latency of a single sample into an empty, idle buffer
    s_valid = 1'b1; s_data = 11'h055;
    @(negedge clk);
    s_valid = 1'b0;
    chk_eq("lat_vin_k", vin0, 0);
    chk_eq("lat_level", level0, 1);
    @(negedge clk);
    chk_eq("lat_vin_k1", vin0, 1);
    chk_eq("lat_din", din0, 11'h055);
    repeat (8) @(negedge clk);

    // Fill to full by holding coef_load (each commit stalls issue), then burst
    coef_load = 1'b1; s_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_data = DW'(i);
      @(negedge clk);
    end
    s_data = 11'h099;
    chk_eq("full_level", level0, 8);
    chk_eq("full_ready", s_ready0, 0);
    chk_eq("full_vin", vin0, 0);
    @(negedge clk);
    chk_eq("full_hold", level0, 8);
    s_valid = 1'b0; coef_load = 1'b0;
    n = 0;
    while (!vin0 && n < 10) begin @(negedge clk); n++; end
    chk_eq("run_start", vin0, 1);
    run = 0;
    while (vin0 && run < 20) begin run++; @(negedge clk); end
    chk_eq("run_len", run, 8);
    chk_eq("run_level", level0, 0);
    repeat (30) @(negedge clk);

    // GAP=2 pacing
    rec2 = 1'b1;
    s_valid = 1'b1;
    s_data = 11'h003; @(negedge clk);
    s_data = 11'h7FB; @(negedge clk);
    s_data = 11'h3FF; @(negedge clk);
    s_valid = 1'b0;
    repeat (15) @(negedge clk);
    rec2 = 1'b0;
    chk_eq("gap2_cnt", t2.size(), 3);
    if (t2.size() == 3) begin
      chk_eq("gap2_d1", t2[1] - t2[0], 3);
      chk_eq("gap2_d2", t2[2] - t2[1], 3);
    end
    chk_eq("gap2_level", level2, 0);

    // Coefficient update mid-stream at GAP=0
    chk_eq("t4_a1_pre", a1_0, 0);
    coef_a1 = 11'h100; coef_b1 = 11'h080; coef_b0 = 11'h040;
    for (int c = 0; c < 24; c++) begin
      vh[c] = vin0; ph[c] = coef_pend0;
      a1h[c] = a1_0; b1h[c] = b1_0; b0h[c] = b0_0;
      s_valid = (c < 12);
      s_data = DW'(12'h200 + c);
      coef_load = (c == 6);
      @(negedge clk);
    end
    chk_eq("t4_pend_set", ph[7], 1);
    chk_eq("t4_pend_clr", ph[8], 0);
    chk_eq("t4_vin_before", vh[7], 1);
    chk_eq("t4_a1_before", a1h[7], 0);
    chk_eq("t4_bubble_vin", vh[8], 0);
    chk_eq("t4_bubble_a1", a1h[8], 11'h100);
    chk_eq("t4_bubble_b1", b1h[8], 11'h080);
    chk_eq("t4_bubble_b0", b0h[8], 11'h040);
    first = -1; last = -1; ones = 0; gaps = 0;
    for (int c = 0; c < 24; c++) begin
      if (vh[c]) begin
        if (first < 0) first = c;
        last = c;
        ones++;
      end
    end
    if (first >= 0) begin
      for (int c = first; c <= last; c++) if (!vh[c]) gaps++;
    end
    chk_eq("t4_strobes", ones, 12);
    chk_eq("t4_bubbles", gaps, 1);
    repeat (5) @(negedge clk);

    // Flush with queued samples and a concurrent push
    coef_load = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = DW'(12'h300 + i);
      @(negedge clk);
    end
    chk_eq("fl_level_pre", level0, 5);
    flush = 1'b1; coef_load = 1'b0; s_data = 11'h3AB;
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0;
    chk_eq("fl_level", level0, 0);
    chk_eq("fl_vin", vin0, 0);
    chk_eq("fl_ready", s_ready0, 1);
    @(negedge clk);
    chk_eq("fl_vin2", vin0, 0);
    chk_eq("fl_level2", level0, 0);
    vref = vcount0;
    s_valid = 1'b1;
    s_data = 11'h123; @(negedge clk);
    s_data = 11'h124; @(negedge clk);
    s_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk_eq("fl_after", vcount0 - vref, 2);

    // Random valid/stall traffic across pointer wraps
    base = acc0; n = 0;
    while ((acc0 - base) < 20 && n < 400) begin
      s_valid   = 1'($urandom_range(0, 1));
      s_data    = DW'($urandom);
      coef_load = ($urandom_range(0, 3) == 0);
      coef_a1   = DW'($urandom);
      coef_b1   = DW'($urandom);
      coef_b0   = DW'($urandom);
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0; coef_load = 1'b0;
    chk_eq("wrap_accepts", acc0 - base, 20);
    repeat (60) @(negedge clk);
    chk_eq("wrap_q0", q0.size(), 0);
    chk_eq("wrap_q2", q2.size(), 0);
    chk_eq("wrap_level0", level0, 0);
    chk_eq("wrap_level2", level2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
